uart_ram_loader: RTL
====================

Name: uart_ram_loader

Overview:
- Parameterised successor to the on-chip UART RAM programmer.
- Consumes a received byte stream from the UART receiver and detects a configurable sync sequence. It then reads a word count and writes that many words into program RAM from a base address, using a RAM-side ready handshake.
- Finally it issues a fixed-length system reset pulse to the core.
- Sits between the UART receiver and the RAM write port. The RAM port is muxed in by the RAM wrapper while prog_mode_o is high.

Parameters:
- ADDR_W, 17, RAM word-address width.
- WORD_BYTES, 4, bytes per RAM word; width of ram_wstrb_o.
- SYNC_LEN, 9, sync sequence length in bytes (1..16).
- SYNC_SEQ, "TEKNOFEST", sync bytes, first-received byte in the MSB; SYNC_LEN*8 bits wide.
- LEN_BYTES, 4, bytes in the word-count field, received MSB first (1..4).
- BASE_ADDR, 0, first RAM word address written.
- BIG_ENDIAN, 1, 1: first data byte goes to the MSB of the word; 0: first byte goes to byte lane 0.
- TIMEOUT_CYC, 1000000, idle cycles without rx_valid_i before a load is aborted.
- RST_PULSE, 16, sys_rst_o pulse length in cycles (>=1).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous, active-high reset.
- rx_valid_i  in  1  one-cycle strobe: rx_data_i holds a new byte.
- rx_data_i  in  8  received byte.
- ram_we_o  out  1  write request; held until accepted.
- ram_ready_i  in  1  RAM accepts the write in any cycle where ram_we_o && ram_ready_i.
- ram_addr_o  out  ADDR_W  write word address.
- ram_wdata_o  out  WORD_BYTES*8  write data.
- ram_wstrb_o  out  WORD_BYTES  byte enables; all ones while ram_we_o is high.
- prog_mode_o  out  1  high in states LEN, DATA and CHK.
- sys_rst_o  out  1  active-high core reset pulse.
- done_o  out  1  one-cycle strobe on successful completion.
- err_o  out  1  sticky error flag; cleared when the next sync sequence is detected.

Behaviour:
- Reset: all outputs 0, state IDLE, sync shift register 0, all counters 0.
- IDLE:
  - Every rx_valid_i shifts rx_data_i into a SYNC_LEN-byte shift register.
  - When the shifted-in value equals SYNC_SEQ, go to LEN in the same cycle that byte arrives. Clear the byte counter and err_o.
  - Detection is a sliding window: an overlapping prefix such as "TTEKNOFEST" still matches.
- LEN:
  - Shift LEN_BYTES bytes, MSB first, into count N.
  - After the last byte: N==0 goes to FINISH with no writes; otherwise go to DATA with word index 0.
- DATA:
  - Assemble WORD_BYTES bytes per word in the order set by BIG_ENDIAN.
  - On the cycle after the last byte of a word: ram_we_o=1, ram_addr_o=(BASE_ADDR+index) mod 2^ADDR_W, ram_wstrb_o all ones.
  - ram_we_o and the address/data outputs stay stable until ram_ready_i is high. Index increments on acceptance.
  - Address wraps silently modulo 2^ADDR_W.
  - Overrun: if the next word completes while the previous write is still pending, set err_o and go to IDLE. The pending write is dropped.
  - After word N-1 is accepted, go to CHK if LOADER_CHECKSUM_EN is defined, otherwise to FINISH.
- Timeout:
  - In LEN, DATA and CHK an idle counter resets on every rx_valid_i and increments otherwise.
  - A counter value of TIMEOUT_CYC sets err_o, drops ram_we_o and returns to IDLE. No sys_rst_o is issued.
  - The timeout is not evaluated while a write is pending and no byte is expected.
- FINISH:
  - sys_rst_o high for exactly RST_PULSE cycles. done_o pulses on the first of those cycles.
  - Then return to IDLE. rx_valid_i is ignored during FINISH.
- Simultaneous events: a byte arriving in the same cycle the timeout fires is discarded; the abort wins.
- rst_i mid-load: immediate return to IDLE. ram_we_o and sys_rst_o drop asynchronously.
- Bytes stay accepted at any rate up to one per cycle. The RAM may stall up to one word-time without loss.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit XOR of all data bytes, excluding the length field, is accumulated during DATA.
  - State CHK receives one further byte.
  - Match: go to FINISH.
  - Mismatch: set err_o and go to IDLE with no sys_rst_o and no done_o. RAM contents written so far remain.
- Undefined: no CHK state and no checksum byte; DATA goes straight to FINISH.

Test Plan:
- Happy path: send "TEKNOFEST", 00 00 00 02, 11 22 33 44, AA BB CC DD, with ram_ready_i=1 -> writes 0x11223344 @0 and 0xAABBCCDD @1; done_o=1 once; sys_rst_o high for 16 cycles.
- BIG_ENDIAN=0 with the same stream -> word 0 = 0x44332211.
- Overlap and garbage: send "XTTEKNOFEST", then length 1 and word 01020304 -> exactly one write, to address 0.
- Backpressure: hold ram_ready_i=0 for 5 cycles on word 0 -> ram_we_o, address and data stable all 5 cycles; single acceptance; no err_o.
- Timeout: stop after 2 data bytes, TIMEOUT_CYC=100 -> err_o=1 at idle cycle 100; no writes; no sys_rst_o. A fresh sync then clears err_o.
- Checksum (macro defined): data 11 22 33 44 plus check byte 44 -> done_o. Check byte 00 -> err_o=1 and no sys_rst_o. Also apply rst_i mid-DATA -> ram_we_o=0 immediately and state IDLE.

Source files
------------

// File: rtl/uart_ram_loader.sv
// rtl/uart_ram_loader.sv - UART byte-stream RAM loader: sync detect, word count, RAM writes, core reset pulse.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module uart_ram_loader #(
    parameter int                        ADDR_W      = 17,
    parameter int                        WORD_BYTES  = 4,
    parameter int                        SYNC_LEN    = 9,
    parameter logic [SYNC_LEN*8-1:0]     SYNC_SEQ    = "TEKNOFEST",
    parameter int                        LEN_BYTES   = 4,
    parameter int                        BASE_ADDR   = 0,
    parameter int                        BIG_ENDIAN  = 1,
    parameter int                        TIMEOUT_CYC = 1000000,
    parameter int                        RST_PULSE   = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    rx_valid_i,
    input  logic [7:0]              rx_data_i,
    output logic                    ram_we_o,
    input  logic                    ram_ready_i,
    output logic [ADDR_W-1:0]       ram_addr_o,
    output logic [WORD_BYTES*8-1:0] ram_wdata_o,
    output logic [WORD_BYTES-1:0]   ram_wstrb_o,
    output logic                    prog_mode_o,
    output logic                    sys_rst_o,
    output logic                    done_o,
    output logic                    err_o
);

    localparam int SYNC_W = SYNC_LEN * 8;
    localparam int WORD_W = WORD_BYTES * 8;
    localparam int CNT_W  = LEN_BYTES * 8;
    localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);
    localparam int RP_W   = $clog2(RST_PULSE + 1);
    localparam int BC_W   = $clog2(WORD_BYTES + LEN_BYTES + 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LEN    = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_CHK    = 3'd3;
    localparam logic [2:0] ST_FINISH = 3'd4;

    logic [2:0]        r_state;
    logic [SYNC_W-1:0] r_sync_sr;
    logic [BC_W-1:0]   r_byte_cnt;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_index;
    logic [CNT_W-1:0]  r_wcnt;
    logic [WORD_W-1:0] r_asm;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [WORD_W-1:0] r_wdata;
    logic [TO_W-1:0]   r_idle_cnt;
    logic [RP_W-1:0]   r_pulse_cnt;
    logic              r_sys_rst;
    logic              r_done;
    logic              r_err;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        r_csum;
    logic              r_chk_got;
    logic [7:0]        r_chk_byte;
`endif

    logic [SYNC_W-1:0] w_sync_next;
    logic [CNT_W-1:0]  w_count_next;
    logic [WORD_W-1:0] w_asm_next;
    logic [CNT_W-1:0]  w_index_inc;
    logic [CNT_W-1:0]  w_index_eff;
    logic              w_accept;
    logic              w_all_words;
    logic              w_no_byte_exp;
    logic              w_to_eval;
    logic              w_load_state;
    logic              w_timeout;

    assign w_sync_next  = (r_sync_sr << 8) | SYNC_W'(rx_data_i);
    assign w_count_next = (r_count << 8) | CNT_W'(rx_data_i);
    assign w_accept     = r_we & ram_ready_i;
    assign w_index_inc  = r_index + CNT_W'(1);
    assign w_index_eff  = w_accept ? w_index_inc : r_index;
    assign w_all_words  = (r_wcnt == r_count);
    assign w_load_state = (r_state == ST_LEN) || (r_state == ST_DATA) || (r_state == ST_CHK);

    always_comb begin
        w_asm_next = '0;
        if (BIG_ENDIAN != 0)
            w_asm_next = (r_asm << 8) | WORD_W'(rx_data_i);
        else
            w_asm_next = (r_asm >> 8) | (WORD_W'(rx_data_i) << (WORD_W - 8));
    end

    // A pending write with nothing left to receive is the RAM's stall, not the sender's.
`ifdef LOADER_CHECKSUM_EN
    assign w_no_byte_exp = (r_state == ST_DATA) && w_all_words && r_chk_got;
`else
    assign w_no_byte_exp = (r_state == ST_DATA) && w_all_words;
`endif
    assign w_to_eval = !(r_we && w_no_byte_exp);
    assign w_timeout = w_load_state && w_to_eval && (r_idle_cnt == TO_W'(TIMEOUT_CYC));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_sync_sr   <= '0;
            r_byte_cnt  <= '0;
            r_count     <= '0;
            r_index     <= '0;
            r_wcnt      <= '0;
            r_asm       <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_idle_cnt  <= '0;
            r_pulse_cnt <= '0;
            r_sys_rst   <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_csum      <= '0;
            r_chk_got   <= 1'b0;
            r_chk_byte  <= '0;
`endif
        end else begin
            r_done <= 1'b0;

            if (!w_load_state || rx_valid_i)
                r_idle_cnt <= '0;
            else if (w_to_eval && (r_idle_cnt != TO_W'(TIMEOUT_CYC)))
                r_idle_cnt <= r_idle_cnt + TO_W'(1);

            case (r_state)
                ST_IDLE: begin
                    if (rx_valid_i) begin
                        r_sync_sr <= w_sync_next;
                        if (w_sync_next == SYNC_SEQ) begin
                            r_state    <= ST_LEN;
                            r_err      <= 1'b0;
                            r_byte_cnt <= '0;
                            r_count    <= '0;
                            r_index    <= '0;
                            r_wcnt     <= '0;
                            r_asm      <= '0;
`ifdef LOADER_CHECKSUM_EN
                            r_csum     <= '0;
                            r_chk_got  <= 1'b0;
`endif
                        end
                    end
                end

                ST_LEN: begin
                    if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= ST_IDLE;
                    end else if (rx_valid_i) begin
                        r_count <= w_count_next;
                        if (r_byte_cnt == BC_W'(LEN_BYTES - 1)) begin
                            r_byte_cnt <= '0;
                            if (w_count_next == '0) begin
                                r_state     <= ST_FINISH;
                                r_sys_rst   <= 1'b1;
                                r_done      <= 1'b1;
                                r_pulse_cnt <= RP_W'(1);
                            end else begin
                                r_state <= ST_DATA;
                            end
                        end else begin
                            r_byte_cnt <= r_byte_cnt + BC_W'(1);
                        end
                    end
                end

                ST_DATA: begin
                    if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_we    <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        if (w_accept) begin
                            r_we    <= 1'b0;
                            r_index <= w_index_inc;
                            if (w_index_inc == r_count) begin
`ifdef LOADER_CHECKSUM_EN
                                r_state     <= ST_CHK;
`else
                                r_state     <= ST_FINISH;
                                r_sys_rst   <= 1'b1;
                                r_done      <= 1'b1;
                                r_pulse_cnt <= RP_W'(1);
`endif
                            end
                        end
                        if (rx_valid_i && !w_all_words) begin
`ifdef LOADER_CHECKSUM_EN
                            r_csum <= r_csum ^ rx_data_i;
`endif
                            if (r_byte_cnt == BC_W'(WORD_BYTES - 1)) begin
                                r_byte_cnt <= '0;
                                r_asm      <= '0;
                                // Overrun: the previous word is still unaccepted, so it is dropped.
                                if (r_we && !ram_ready_i) begin
                                    r_err   <= 1'b1;
                                    r_we    <= 1'b0;
                                    r_state <= ST_IDLE;
                                end else begin
                                    r_we    <= 1'b1;
                                    r_wdata <= w_asm_next;
                                    r_addr  <= ADDR_W'(BASE_ADDR) + ADDR_W'(w_index_eff);
                                    r_wcnt  <= r_wcnt + CNT_W'(1);
                                end
                            end else begin
                                r_asm      <= w_asm_next;
                                r_byte_cnt <= r_byte_cnt + BC_W'(1);
                            end
                        end
`ifdef LOADER_CHECKSUM_EN
                        else if (rx_valid_i && !r_chk_got) begin
                            r_chk_got  <= 1'b1;
                            r_chk_byte <= rx_data_i;
                        end
`endif
                    end
                end

`ifdef LOADER_CHECKSUM_EN
                ST_CHK: begin
                    if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= ST_IDLE;
                    end else if (r_chk_got || rx_valid_i) begin
                        if ((r_chk_got ? r_chk_byte : rx_data_i) == r_csum) begin
                            r_state     <= ST_FINISH;
                            r_sys_rst   <= 1'b1;
                            r_done      <= 1'b1;
                            r_pulse_cnt <= RP_W'(1);
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end
                end
`endif

                ST_FINISH: begin
                    if (r_pulse_cnt == RP_W'(RST_PULSE)) begin
                        r_sys_rst   <= 1'b0;
                        r_pulse_cnt <= '0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_pulse_cnt <= r_pulse_cnt + RP_W'(1);
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ram_we_o    = r_we;
    assign ram_addr_o  = r_addr;
    assign ram_wdata_o = r_wdata;
    assign ram_wstrb_o = {WORD_BYTES{r_we}};
    assign prog_mode_o = w_load_state;
    assign sys_rst_o   = r_sys_rst;
    assign done_o      = r_done;
    assign err_o       = r_err;

endmodule
